mmu_walk_arbiter: RTL and testbench



---
 rtl/mmu_walk_arbiter.sv | 126 ++++++++++++
 tb/tb_mmu_walk_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_walk_arbiter.sv
// Round-robin arbiter sharing one page-table-walk port between NUM_PORTS TLB miss
// requesters, with one walk outstanding and a response timeout for forward progress.
module mmu_walk_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 88,
    parameter int RESP_WIDTH = 64,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            i_req_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_PORTS-1:0]            o_req_ready,
    output logic                            o_walk_valid,
    output logic [DATA_WIDTH-1:0]           o_walk_data,
    output logic [2:0]                      o_walk_id,
    input  logic                            i_walk_ready,
    input  logic                            i_resp_valid,
    input  logic [RESP_WIDTH-1:0]           i_resp_data,
    output logic [NUM_PORTS-1:0]            o_resp_valid,
    output logic [RESP_WIDTH-1:0]           o_resp_data,
    output logic                            o_resp_err,
    output logic                            o_busy,
    output logic                            o_spurious
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state;
    logic [2:0]              ptr;
    logic [2:0]              g;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              winner;
    logic                    found;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [7:0]              req_pad;
    logic [7:0]              ready_pad;
    logic [7:0]              resp_pad;
    logic                    timeout_hit;
    logic                    resp_fire;
    int                      cand;

    assign req_pad = 8'(i_req_valid);

    // Rotating priority search starting at ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        cand     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (int'(ptr) + i) % NUM_PORTS;
            if (!found && req_pad[cand[2:0]]) begin
                found    = 1'b1;
                winner   = cand[2:0];
                win_data = i_req_data[cand*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Handshakes are valid/ready: a transfer happens on the rising edge where both
    // are high; the source holds valid and payload stable until it sees ready.
    assign ready_pad    = (state == IDLE && found && !rst) ? (8'd1 << winner) : 8'd0;
    assign o_req_ready  = ready_pad[NUM_PORTS-1:0];

    assign timeout_hit  = TO_EN && (cnt == TO_LAST);
    assign resp_fire    = (state == WAIT_RESP) && !rst && (i_resp_valid || timeout_hit);
    assign resp_pad     = resp_fire ? (8'd1 << g) : 8'd0;
    assign o_resp_valid = resp_pad[NUM_PORTS-1:0];
    assign o_resp_err   = resp_fire && !i_resp_valid;
    assign o_resp_data  = o_resp_err ? '0 : i_resp_data;
    assign o_walk_id    = g;
    assign o_busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            g            <= '0;
            cnt          <= '0;
            o_walk_valid <= 1'b0;
            o_walk_data  <= '0;
            o_spurious   <= 1'b0;
        end else begin
            // A response with no walk outstanding (including after a timeout) is dropped.
            if (i_resp_valid && state != WAIT_RESP) begin
                o_spurious <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        g            <= winner;
                        o_walk_data  <= win_data;
                        o_walk_valid <= 1'b1;
                        ptr          <= (winner == 3'(NUM_PORTS - 1)) ? 3'd0 : winner + 3'd1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_walk_ready) begin
                        o_walk_valid <= 1'b0;
                        cnt          <= '0;
                        state        <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (i_resp_valid || timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_walk_arbiter.sv
// Randomized bench for mmu_walk_arbiter: a transaction-level requester/walker model
// feeds expected-value queues that a free-running monitor pops and compares.
module tb_mmu_walk_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int RW = 16;
    localparam int TO = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      i_req_valid;
    logic [N*DW-1:0]   i_req_data;
    logic [N-1:0]      o_req_ready;
    logic              o_walk_valid;
    logic [DW-1:0]     o_walk_data;
    logic [2:0]        o_walk_id;
    logic              i_walk_ready;
    logic              i_resp_valid;
    logic [RW-1:0]     i_resp_data;
    logic [N-1:0]      o_resp_valid;
    logic [RW-1:0]     o_resp_data;
    logic              o_resp_err;
    logic              o_busy;
    logic              o_spurious;

    mmu_walk_arbiter #(
        .NUM_PORTS(N), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
        .o_walk_valid(o_walk_valid), .o_walk_data(o_walk_data), .o_walk_id(o_walk_id),
        .i_walk_ready(i_walk_ready),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .o_resp_err(o_resp_err),
        .o_busy(o_busy), .o_spurious(o_spurious)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model state
    int             checks = 0;
    int             errors = 0;
    int             m_ptr  = 0;
    logic           pend_v[N];
    logic [DW-1:0]  pend_d[N];
    logic           exp_busy       = 1'b0;
    logic           exp_walk_valid = 1'b0;
    logic           exp_spurious   = 1'b0;
    bit             mon_en = 1'b0;
    bit             all_req = 1'b0;
    bit             no_new = 1'b0;

    // scoreboard queues
    logic [N-1:0]      exp_grant_q[$];
    logic [DW+2:0]     exp_walk_q[$];
    logic [N+RW:0]     exp_resp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic add_reqs();
        for (int p = 0; p < N; p++) begin
            if (!pend_v[p] && (all_req || $urandom_range(0, 2) == 0)) begin
                pend_v[p] = 1'b1;
                pend_d[p] = DW'($urandom);
            end
        end
    endtask

    task automatic drive_reqs();
        for (int p = 0; p < N; p++) begin
            i_req_valid[p]          = pend_v[p];
            i_req_data[p*DW +: DW]  = pend_d[p];
        end
    endtask

    function automatic int pick_winner();
        for (int i = 0; i < N; i++) begin
            if (pend_v[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic run_txn(input bit force_to);
        int w;
        int stall;
        int d;
        int guard;
        w = -1;
        guard = 0;
        while (w < 0) begin
            if (!no_new) add_reqs();
            if (guard > 20 && !pend_v[0]) begin
                pend_v[0] = 1'b1;
                pend_d[0] = DW'($urandom);
            end
            exp_busy = 1'b0; exp_walk_valid = 1'b0;
            i_walk_ready = 1'b0; i_resp_valid = 1'b0;
            drive_reqs();
            w = pick_winner();
            if (w >= 0) begin
                exp_grant_q.push_back(N'(1) << w);
                exp_walk_q.push_back({3'(w), pend_d[w]});
            end
            guard++;
            @(negedge clk);
        end
        pend_v[w] = 1'b0;
        m_ptr = (w + 1) % N;
        stall = all_req ? 0 : $urandom_range(0, 4);
        for (int s = 0; s <= stall; s++) begin
            if (!no_new) add_reqs();
            drive_reqs();
            exp_busy = 1'b1; exp_walk_valid = 1'b1;
            i_walk_ready = (s == stall);
            @(negedge clk);
        end
        d = force_to ? TO + 5 : (all_req ? 0 : $urandom_range(0, TO + 1));
        for (int c = 0; c < TO + 6; c++) begin
            if (!no_new) add_reqs();
            drive_reqs();
            exp_busy = 1'b1; exp_walk_valid = 1'b0;
            i_walk_ready = 1'b0;
            i_resp_data = RW'($urandom);
            if (c == d) begin
                i_resp_valid = 1'b1;
                exp_resp_q.push_back({N'(1) << w, i_resp_data, 1'b0});
                @(negedge clk);
                break;
            end else if (c == TO - 1) begin
                i_resp_valid = 1'b0;
                exp_resp_q.push_back({N'(1) << w, RW'(0), 1'b1});
                @(negedge clk);
                break;
            end
            i_resp_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic idle_cycle(input logic resp);
        drive_reqs();
        exp_busy = 1'b0; exp_walk_valid = 1'b0;
        i_walk_ready = 1'b0; i_resp_valid = resp;
        @(negedge clk);
        i_resp_valid = 1'b0;
    endtask

    // monitor
    logic [N-1:0]  mon_grant;
    logic [DW+2:0] mon_walk;
    logic [N+RW:0] mon_resp;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                mon_grant = (exp_grant_q.size() != 0) ? exp_grant_q.pop_front() : '0;
                check("req_ready", 64'(o_req_ready), 64'(mon_grant));
                check("walk_valid", 64'(o_walk_valid), 64'(exp_walk_valid));
                if (exp_walk_valid && exp_walk_q.size() != 0) begin
                    mon_walk = exp_walk_q[0];
                    check("walk_id", 64'(o_walk_id), 64'(mon_walk[DW+2:DW]));
                    check("walk_data", 64'(o_walk_data), 64'(mon_walk[DW-1:0]));
                    if (i_walk_ready) void'(exp_walk_q.pop_front());
                end
                if (exp_resp_q.size() != 0) begin
                    mon_resp = exp_resp_q.pop_front();
                    check("resp_valid", 64'(o_resp_valid), 64'(mon_resp[N+RW:RW+1]));
                    check("resp_data", 64'(o_resp_data), 64'(mon_resp[RW:1]));
                    check("resp_err", 64'(o_resp_err), 64'(mon_resp[0]));
                end else begin
                    check("resp_valid_idle", 64'(o_resp_valid), 64'(0));
                    check("resp_err_idle", 64'(o_resp_err), 64'(0));
                end
                check("busy", 64'(o_busy), 64'(exp_busy));
                check("spurious", 64'(o_spurious), 64'(exp_spurious));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(o_req_ready), 64'(0));
        check({tag, "_resp_valid"}, 64'(o_resp_valid), 64'(0));
        check({tag, "_resp_err"}, 64'(o_resp_err), 64'(0));
        check({tag, "_walk_valid"}, 64'(o_walk_valid), 64'(0));
        check({tag, "_walk_data"}, 64'(o_walk_data), 64'(0));
        check({tag, "_walk_id"}, 64'(o_walk_id), 64'(0));
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
        check({tag, "_spurious"}, 64'(o_spurious), 64'(0));
    endtask

    initial begin
        for (int p = 0; p < N; p++) begin
            pend_v[p] = 1'b0;
            pend_d[p] = '0;
        end
        rst = 1'b1;
        i_req_valid = '1; i_req_data = '0;
        i_walk_ready = 1'b0; i_resp_valid = 1'b1; i_resp_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        i_req_valid = '0; i_resp_valid = 1'b0;
        mon_en = 1'b1;

        // all ports requesting, walker always ready, immediate response: strict rotation
        all_req = 1'b1;
        repeat (3 * N) run_txn(1'b0);
        all_req = 1'b0;

        repeat (150) run_txn(1'b0);

        // drain, then timeout followed by a late (spurious) response
        no_new = 1'b1;
        while (pick_winner() >= 0) run_txn(1'b0);
        pend_v[1] = 1'b1; pend_d[1] = DW'(16'h00A5);
        run_txn(1'b1);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        exp_spurious = 1'b1;
        idle_cycle(1'b0);

        // reset while waiting on a response from port 1
        pend_v[1] = 1'b1; pend_d[1] = DW'($urandom);
        drive_reqs();
        exp_busy = 1'b0; exp_walk_valid = 1'b0; i_walk_ready = 1'b0;
        exp_grant_q.push_back(N'(1) << 1);
        exp_walk_q.push_back({3'd1, pend_d[1]});
        @(negedge clk);
        pend_v[1] = 1'b0;
        m_ptr = 2;
        drive_reqs();
        exp_busy = 1'b1; exp_walk_valid = 1'b1; i_walk_ready = 1'b1;
        @(negedge clk);
        exp_walk_valid = 1'b0; i_walk_ready = 1'b0;
        #3;
        mon_en = 1'b0;
        i_req_valid = '1;
        i_resp_valid = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        i_resp_valid = 1'b0;
        exp_spurious = 1'b0;
        exp_grant_q.delete(); exp_walk_q.delete(); exp_resp_q.delete();
        m_ptr = 0;
        mon_en = 1'b1;
        pend_v[1] = 1'b1; pend_d[1] = DW'($urandom);
        pend_v[2] = 1'b1; pend_d[2] = DW'($urandom);
        run_txn(1'b0);
        run_txn(1'b0);
        idle_cycle(1'b0);
        mon_en = 1'b0;

        check("grant_q_empty", 64'(exp_grant_q.size()), 64'(0));
        check("walk_q_empty", 64'(exp_walk_q.size()), 64'(0));
        check("resp_q_empty", 64'(exp_resp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
